// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL reset pulse, lock qualification and system reset release sequencer.
// Latency: pll_locked_i is 2-flop synced; all outputs registered off the next state; no backpressure.
module pll_reset_ctrl #(
  parameter int RST_PULSE_CYCLES   = 64,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  input  logic       sw_restart_i,
  output logic       pll_rst_o,
  output logic       sys_rst_n_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o
);

  localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_cnt_q, retry_cnt_d;
  logic [3:0]    retry_inc;
  logic          lk_meta_q, lk_meta_d;
  logic          lk_s_q, lk_s_d;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_n_q, sys_rst_n_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;

  // pll_locked_i is asynchronous to clk; only lk_s_q is used by the FSM.
  always_comb begin
    lk_meta_d = pll_locked_i;
    lk_s_d    = lk_meta_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_cnt_d = retry_cnt_q;
    retry_inc   = (retry_cnt_q >= RETRY_MAX) ? RETRY_MAX : retry_cnt_q + 4'd1;

    case (state_q)
      S_RESET_PLL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PULSE_LAST) begin
          state_d = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        cnt_d = cnt_q + 1'b1;
        if (lk_s_q) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_cnt_d = retry_inc;
          state_d     = (retry_inc == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
        end
      end
      S_STABLE: begin
        cnt_d = cnt_q + 1'b1;
        if (!lk_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d     = S_RUN;
          retry_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (!lk_s_q) begin
          state_d = S_RESET_PLL;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_RESET_PLL;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    // A software restart wins over any same-cycle timeout or lock loss.
    if (sw_restart_i) begin
      state_d     = S_RESET_PLL;
      cnt_d       = '0;
      retry_cnt_d = '0;
    end

    // Outputs are decoded from the next state so the flops track the state register exactly.
    pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    sys_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_cnt_q <= '0;
      lk_meta_q   <= 1'b0;
      lk_s_q      <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_cnt_q <= retry_cnt_d;
      lk_meta_q   <= lk_meta_d;
      lk_s_q      <= lk_s_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign sys_rst_n_o = sys_rst_n_q;
  assign ready_o     = ready_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_cnt_q;

endmodule
